vga_text_renderer: RTL and testbench

- Text-mode pixel pipeline for 640x480 VGA, the stage directly upstream of the 1-bit IBM font ROM.
- Converts the raster position into an address into an external text buffer RAM.
- Turns the returned character code into a 14-bit font address and consumes the font bit the ROM returns one cycle later.
- Emits a 12-bit RGB pixel with hsync/vsync delayed to match, and overlays inverse video and a blinking underline cursor.

---
 rtl/vga_text_renderer.sv | 151 +++++++++++++++
 tb/tb_vga_text_renderer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: raster position -> text RAM -> font ROM -> RGB, 5-clock fixed latency.
// No backpressure: text RAM and font ROM are assumed to answer exactly one cycle after their address.
module vga_text_renderer #(
    parameter int          H_CHARS      = 80,
    parameter int          V_CHARS      = 30,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] text_addr,
    input  logic [7:0]  text_data,
    output logic [13:0] font_addr,
    input  logic        font_bit,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_out
);

    localparam logic [11:0] H_CHARS_W  = 12'(H_CHARS);
    localparam logic [6:0]  H_LIMIT    = 7'(H_CHARS);
    localparam logic [4:0]  V_LIMIT    = 5'(V_CHARS);
    localparam logic [9:0]  TICK_LINE  = 10'(V_CHARS * 16);
    localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);

    // Sideband shift registers, index n = value seen during cycle Tn.
    logic [4:1]  act_q, act_d;
    logic [4:1]  hs_q, hs_d;
    logic [4:1]  vs_q, vs_d;
    logic [4:1]  hit_q, hit_d;
    logic [3:0]  row1_q, row1_d, row2_q, row2_d;
    logic [2:0]  col1_q, col1_d, col2_q, col2_d;
    logic        inv3_q, inv3_d, inv4_q, inv4_d;
    logic [11:0] text_addr_q, text_addr_d;
    logic [13:0] font_addr_q, font_addr_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_out_q, hsync_out_d;
    logic        vsync_out_q, vsync_out_d;
    logic        active_out_q, active_out_d;
    logic [5:0]  blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;

    logic        frame_tick;
    logic [6:0]  cell_col;
    logic [4:0]  cell_row;
    logic        hit0;
    logic        pix_on;

    always_comb begin
        frame_tick  = (vcount_in == TICK_LINE) && (hcount_in == 10'd0);
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 6'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end
        end

        cell_col = hcount_in[9:3];
        cell_row = vcount_in[8:4];
        // Out-of-range cursor positions must never light, even in aliased blanking cells.
        hit0 = cursor_en && phase_q
            && (cursor_col < H_LIMIT) && (cursor_row < V_LIMIT)
            && (cell_col == cursor_col) && (cell_row == cursor_row)
            && (vcount_in[3:1] == 3'b111);

        text_addr_d = active_in ? (12'(cell_row) * H_CHARS_W + 12'(cell_col)) : 12'd0;

        act_d  = {act_q[3:1], active_in};
        hs_d   = {hs_q[3:1], hsync_in};
        vs_d   = {vs_q[3:1], vsync_in};
        hit_d  = {hit_q[3:1], hit0};
        row1_d = vcount_in[3:0];
        row2_d = row1_q;
        col1_d = hcount_in[2:0];
        col2_d = col1_q;

        font_addr_d = {text_data[6:0], row2_q, col2_q};
        inv3_d      = text_data[7];
        inv4_d      = inv3_q;

        pix_on       = font_bit ^ inv4_q ^ hit_q[4];
        rgb_d        = act_q[4] ? (pix_on ? FG_RGB : BG_RGB) : 12'd0;
        hsync_out_d  = hs_q[4];
        vsync_out_d  = vs_q[4];
        active_out_d = act_q[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q        <= '0;
            hs_q         <= '1;
            vs_q         <= '1;
            hit_q        <= '0;
            row1_q       <= '0;
            row2_q       <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            inv3_q       <= 1'b0;
            inv4_q       <= 1'b0;
            text_addr_q  <= '0;
            font_addr_q  <= '0;
            rgb_q        <= '0;
            hsync_out_q  <= 1'b1;
            vsync_out_q  <= 1'b1;
            active_out_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            act_q        <= act_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            hit_q        <= hit_d;
            row1_q       <= row1_d;
            row2_q       <= row2_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            inv3_q       <= inv3_d;
            inv4_q       <= inv4_d;
            text_addr_q  <= text_addr_d;
            font_addr_q  <= font_addr_d;
            rgb_q        <= rgb_d;
            hsync_out_q  <= hsync_out_d;
            vsync_out_q  <= vsync_out_d;
            active_out_q <= active_out_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign text_addr  = text_addr_q;
    assign font_addr  = font_addr_q;
    assign rgb_out    = rgb_q;
    assign hsync_out  = hsync_out_q;
    assign vsync_out  = vsync_out_q;
    assign active_out = active_out_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: reset, address mapping, blanking, inverse, cursor blink, sync alignment.
module tb_vga_text_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount_in;
    logic [9:0]  vcount_in;
    logic        active_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [13:0] font_addr;
    logic        font_bit;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        active_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_text_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .active_in  (active_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .text_addr  (text_addr),
        .text_data  (text_data),
        .font_addr  (font_addr),
        .font_bit   (font_bit),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb_out    (rgb_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .active_out (active_out)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_px(input int h, input int v, input logic act);
        hcount_in = 10'(h);
        vcount_in = 10'(v);
        active_in = act;
    endtask

    task automatic frame_ticks(input int n);
        repeat (n) begin
            set_px(0, 480, 1'b0);
            step(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_px(100, 100, 1'b1);
        hsync_in = 1'b0; vsync_in = 1'b0;
        text_data = 8'h41; font_bit = 1'b1;
        cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
        step(1);
        n_checks++;
        if (rgb_out !== 12'h000 || active_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rgb: rgb_out=%h active_out=%b, required 000/0", rgb_out, active_out);
        end
        n_checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sync: hsync_out=%b vsync_out=%b, required 1/1", hsync_out, vsync_out);
        end
        n_checks++;
        if (text_addr !== 12'd0 || font_addr !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_addr: text_addr=%0d font_addr=%h, required 0/0", text_addr, font_addr);
        end
        step(2);
        rst = 1'b0;
        step(4);
        n_checks++;
        if (active_out !== 1'b0 || rgb_out !== 12'h000 || hsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_refill_early: active_out=%b rgb_out=%h hsync_out=%b, required 0/000/1",
                     active_out, rgb_out, hsync_out);
        end
        step(1);
        n_checks++;
        if (active_out !== 1'b1 || rgb_out !== 12'hFFF || hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_pixel: active_out=%b rgb_out=%h hs=%b vs=%b, required 1/FFF/0/0",
                     active_out, rgb_out, hsync_out, vsync_out);
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_addr_map;
        int th[5] = '{0, 15, 8, 320, 639};
        int tv[5] = '{0, 0, 16, 240, 479};
        int te[5] = '{0, 1, 81, 1240, 2399};
        text_data = 8'h41; font_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_px(th[i], tv[i], 1'b1);
            step(1);
            n_checks++;
            if (text_addr !== 12'(te[i])) begin
                n_fail++;
                $display("FAIL addr_map[%0d]: text_addr=%0d, required %0d", i, text_addr, te[i]);
            end
        end
        set_px(8, 16, 1'b1);
        text_data = 8'h5A;
        step(3);
        n_checks++;
        if (font_addr !== 14'h2D00) begin
            n_fail++;
            $display("FAIL font_addr_5a: font_addr=%h, required 2d00", font_addr);
        end
        set_px(637, 479, 1'b1);
        text_data = 8'h41;
        step(1);
        n_checks++;
        if (text_addr !== 12'd2399) begin
            n_fail++;
            $display("FAIL addr_max: text_addr=%0d, required 2399", text_addr);
        end
        step(2);
        n_checks++;
        if (font_addr !== 14'h20FD) begin
            n_fail++;
            $display("FAIL font_addr_41: font_addr=%h, required 20fd", font_addr);
        end
        step(2);
        n_checks++;
        if (rgb_out !== 12'hFFF || active_out !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_pixel: rgb_out=%h active_out=%b, required FFF/1", rgb_out, active_out);
        end
    endtask

    task automatic test_blanking;
        set_px(700, 100, 1'b0);
        text_data = 8'h41; font_bit = 1'b1;
        step(1);
        n_checks++;
        if (text_addr !== 12'd0) begin
            n_fail++;
            $display("FAIL blank_addr: text_addr=%0d, required 0", text_addr);
        end
        step(4);
        n_checks++;
        if (rgb_out !== 12'h000 || active_out !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_rgb: rgb_out=%h active_out=%b, required 000/0", rgb_out, active_out);
        end
    endtask

    task automatic test_inverse;
        logic [7:0]  cd[3] = '{8'hC1, 8'hC1, 8'h41};
        logic        fb[3] = '{1'b1, 1'b0, 1'b0};
        logic [11:0] ex[3] = '{12'h000, 12'hFFF, 12'h000};
        set_px(100, 100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            text_data = cd[i]; font_bit = fb[i];
            step(5);
            n_checks++;
            if (rgb_out !== ex[i] || active_out !== 1'b1) begin
                n_fail++;
                $display("FAIL inverse[%0d]: rgb_out=%h active_out=%b, required %h/1", i, rgb_out, active_out, ex[i]);
            end
        end
    endtask

    task automatic test_cursor_blink;
        int   hp[7]  = '{24, 31, 24, 31, 24, 32, 23};
        int   vp[7]  = '{46, 47, 47, 46, 45, 47, 47};
        logic lit[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   tk[5]  = '{0, 29, 1, 29, 1};
        logic ph[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [11:0] exp_rgb;
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
        text_data = 8'h20; font_bit = 1'b0;
        for (int s = 0; s < 5; s++) begin
            frame_ticks(tk[s]);
            for (int i = 0; i < 7; i++) begin
                set_px(hp[i], vp[i], 1'b1);
                step(5);
                exp_rgb = (ph[s] && lit[i]) ? 12'hFFF : 12'h000;
                n_checks++;
                if (rgb_out !== exp_rgb) begin
                    n_fail++;
                    $display("FAIL blink[s%0d,p%0d] h=%0d v=%0d: rgb_out=%h, required %h",
                             s, i, hp[i], vp[i], rgb_out, exp_rgb);
                end
            end
        end
        frame_ticks(30);
        cursor_col = 7'd90;
        set_px(720, 47, 1'b1);
        step(5);
        n_checks++;
        if (rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL cursor_oor_cell: rgb_out=%h, required 000", rgb_out);
        end
        set_px(24, 47, 1'b1);
        step(5);
        n_checks++;
        if (rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL cursor_oor_other: rgb_out=%h, required 000", rgb_out);
        end
        cursor_col = 7'd3;
        step(5);
        n_checks++;
        if (rgb_out !== 12'hFFF) begin
            n_fail++;
            $display("FAIL cursor_back_lit: rgb_out=%h, required FFF", rgb_out);
        end
        cursor_en = 1'b0;
        step(5);
        n_checks++;
        if (rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL cursor_disabled: rgb_out=%h, required 000", rgb_out);
        end
    endtask

    task automatic test_sync_align;
        cursor_en = 1'b0;
        set_px(200, 200, 1'b1);
        hsync_in = 1'b1; vsync_in = 1'b1;
        text_data = 8'h41; font_bit = 1'b1;
        step(5);
        hsync_in = 1'b0; vsync_in = 1'b0; active_in = 1'b0;
        step(4);
        n_checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1 || active_out !== 1'b1 || rgb_out !== 12'hFFF) begin
            n_fail++;
            $display("FAIL sync_before_edge: hs=%b vs=%b act=%b rgb=%h, required 1/1/1/FFF",
                     hsync_out, vsync_out, active_out, rgb_out);
        end
        step(1);
        n_checks++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b0 || active_out !== 1'b0 || rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL sync_at_edge: hs=%b vs=%b act=%b rgb=%h, required 0/0/0/000",
                     hsync_out, vsync_out, active_out, rgb_out);
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
        step(5);
        n_checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_rise: hs=%b vs=%b, required 1/1", hsync_out, vsync_out);
        end
    endtask

    task automatic test_midframe_reset;
        // Phase is lit on entry; 10 extra ticks leave the blink counter mid-count.
        frame_ticks(10);
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
        text_data = 8'h20; font_bit = 1'b0;
        hsync_in = 1'b0;
        set_px(24, 47, 1'b1);
        step(5);
        n_checks++;
        if (rgb_out !== 12'hFFF || hsync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: rgb_out=%h hsync_out=%b, required FFF/0", rgb_out, hsync_out);
        end
        rst = 1'b1;
        step(1);
        n_checks++;
        if (rgb_out !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1 || active_out !== 1'b0
            || text_addr !== 12'd0 || font_addr !== 14'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rgb=%h hs=%b vs=%b act=%b ta=%0d fa=%h, required 000/1/1/0/0/0",
                     rgb_out, hsync_out, vsync_out, active_out, text_addr, font_addr);
        end
        rst = 1'b0;
        step(4);
        n_checks++;
        if (active_out !== 1'b0 || hsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_refill: active_out=%b hsync_out=%b, required 0/1", active_out, hsync_out);
        end
        step(1);
        n_checks++;
        if (active_out !== 1'b1 || rgb_out !== 12'h000 || hsync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_hidden: active_out=%b rgb_out=%h hsync_out=%b, required 1/000/0",
                     active_out, rgb_out, hsync_out);
        end
        hsync_in = 1'b1;
        frame_ticks(29);
        set_px(24, 47, 1'b1);
        step(5);
        n_checks++;
        if (rgb_out !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_blink_29: rgb_out=%h, required 000", rgb_out);
        end
        frame_ticks(1);
        set_px(24, 47, 1'b1);
        step(5);
        n_checks++;
        if (rgb_out !== 12'hFFF) begin
            n_fail++;
            $display("FAIL mid_blink_30: rgb_out=%h, required FFF", rgb_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_px(0, 0, 1'b0);
        hsync_in = 1'b1; vsync_in = 1'b1;
        text_data = 8'h00; font_bit = 1'b0;
        cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
        test_reset;
        test_addr_map;
        test_blanking;
        test_inverse;
        test_cursor_blink;
        test_sync_align;
        test_midframe_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
